// File: rtl/ysyx_22041752_icache_cmu_pkg.sv
// Shared widths, FSM encodings and line helpers for the icache compare/miss unit.
package ysyx_22041752_icache_cmu_pkg;
    localparam int PC_WD     = 64;
    localparam int INDEX_WD  = 7;
    localparam int OFFSET_WD = 4;
    localparam int TAG_WD    = PC_WD - 11;
    localparam int BUS_WD    = PC_WD + 4;
    localparam int LINE_WD   = 128;
    localparam int SETS      = 1 << INDEX_WD;

    localparam logic [2:0] ST_LOOKUP = 3'd0;
    localparam logic [2:0] ST_REQ    = 3'd1;
    localparam logic [2:0] ST_RECV   = 3'd2;
    localparam logic [2:0] ST_FILL   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Pick 32-bit word sel out of a 128-bit cache line.
    function automatic logic [31:0] line_word(input logic [LINE_WD-1:0] line,
                                              input logic [1:0] sel);
        return line[{sel, 5'b0} +: 32];
    endfunction
endpackage

// File: rtl/ysyx_22041752_icache_cmu_if.sv
// Bus bundle of the icache compare/miss unit: upstream stage, SRAM banks,
// memory refill port and downstream fetch handshake.
interface ysyx_22041752_icache_cmu_if;
    import ysyx_22041752_icache_cmu_pkg::*;

    logic                 rs_to_cs_valid;
    logic [BUS_WD-1:0]    rs_to_cs_bus;
    logic                 cmp_allowin;
    logic [LINE_WD-1:0]   sram_rdata0;
    logic [LINE_WD-1:0]   sram_rdata1;
    logic [LINE_WD-1:0]   sram_rdata2;
    logic [LINE_WD-1:0]   sram_rdata3;
    logic [3:0]           sram_wen;
    logic [INDEX_WD-2:0]  sram_waddr;
    logic [LINE_WD-1:0]   sram_wdata;
    logic                 mem_rd_req;
    logic [PC_WD-1:0]     mem_rd_addr;
    logic                 mem_rd_ready;
    logic                 mem_rd_valid;
    logic [63:0]          mem_rd_data;
    logic                 mem_rd_last;
    logic                 fs_allowin;
    logic                 inst_valid;
    logic [31:0]          inst;
    logic [PC_WD-1:0]     inst_pc;
    logic                 flush;

    modport master (
        input  rs_to_cs_valid, rs_to_cs_bus,
        input  sram_rdata0, sram_rdata1, sram_rdata2, sram_rdata3,
        input  mem_rd_ready, mem_rd_valid, mem_rd_data, mem_rd_last,
        input  fs_allowin, flush,
        output cmp_allowin, sram_wen, sram_waddr, sram_wdata,
        output mem_rd_req, mem_rd_addr, inst_valid, inst, inst_pc
    );

    modport slave (
        output rs_to_cs_valid, rs_to_cs_bus,
        output sram_rdata0, sram_rdata1, sram_rdata2, sram_rdata3,
        output mem_rd_ready, mem_rd_valid, mem_rd_data, mem_rd_last,
        output fs_allowin, flush,
        input  cmp_allowin, sram_wen, sram_waddr, sram_wdata,
        input  mem_rd_req, mem_rd_addr, inst_valid, inst, inst_pc
    );
endinterface

// File: rtl/ysyx_22041752_icache_cmu_tagv.sv
// Tag, valid and FIFO-victim arrays for the 2-way icache, kept in flops.
module ysyx_22041752_icache_cmu_tagv
    import ysyx_22041752_icache_cmu_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [INDEX_WD-1:0] index,
    input  logic [TAG_WD-1:0]   tag,
    output logic                hit0,
    output logic                hit1,
    output logic                victim,
    input  logic                fill_en,
    input  logic                fill_way,
    input  logic [INDEX_WD-1:0] fill_index,
    input  logic [TAG_WD-1:0]   fill_tag
);
    logic [TAG_WD-1:0] tag0 [SETS];
    logic [TAG_WD-1:0] tag1 [SETS];
    logic [SETS-1:0]   valid0;
    logic [SETS-1:0]   valid1;
    logic [SETS-1:0]   fifo;

    assign hit0 = valid0[index] && (tag0[index] == tag);
    assign hit1 = valid1[index] && (tag1[index] == tag);

    // Fill an empty way first (way0 before way1), else follow the per-set FIFO bit.
    always_comb begin
        victim = fifo[index];
        if (!valid0[index])
            victim = 1'b0;
        else if (!valid1[index])
            victim = 1'b1;
    end

    // Valid and FIFO bits: cleared by reset, updated by a line fill.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid0 <= '0;
            valid1 <= '0;
            fifo   <= '0;
        end else if (fill_en) begin
            if (fill_way)
                valid1[fill_index] <= 1'b1;
            else
                valid0[fill_index] <= 1'b1;
            fifo[fill_index] <= ~fifo[fill_index];
        end
    end

    // Tag storage needs no reset; valid bits guard it.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            if (fill_way)
                tag1[fill_index] <= fill_tag;
            else
                tag0[fill_index] <= fill_tag;
        end
    end
endmodule

// File: rtl/ysyx_22041752_icache_cmu.sv
// Icache compare/miss unit: tag compare, hit word select and single-line refill.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  LOOKUP  | compare held request; serve hits straight from SRAM banks
//  REQ     | refill request on the memory port, waiting for ready
//  RECV    | collecting the two 64-bit beats into the line buffer
//  FILL    | one-cycle write of the line into the victim bank and tags
//  DONE    | serve the word from the line buffer (unless cancelled)
module ysyx_22041752_icache_cmu
    import ysyx_22041752_icache_cmu_pkg::*;
(
    input logic clk,
    input logic reset,
    ysyx_22041752_icache_cmu_if.master ifc
);
    logic [2:0]          state;
    logic [2:0]          state_nxt;
    logic                cs_valid;
    logic [PC_WD-1:0]    cs_addr;
    logic [3:0]          cs_bank;
    logic                cancel;
    logic [LINE_WD-1:0]  line_buf;
    logic [LINE_WD-1:0]  hit_line;
    logic [INDEX_WD-1:0] index;
    logic [TAG_WD-1:0]   tag;
    logic                hit0;
    logic                hit1;
    logic                hit;
    logic                victim;
    logic [1:0]          hit_bank;
    logic [1:0]          fill_bank;
    logic                in_lookup;
    logic                fill_en;
    logic                accept;
    logic                out_fire;

    assign index     = cs_addr[OFFSET_WD +: INDEX_WD];
    assign tag       = cs_addr[PC_WD-1 -: TAG_WD];
    assign hit       = hit0 | hit1;
    assign hit_bank  = {hit1, index[INDEX_WD-1]};
    assign fill_bank = {victim, index[INDEX_WD-1]};
    assign in_lookup = (state == ST_LOOKUP);
    assign fill_en   = !reset && (state == ST_FILL);

    ysyx_22041752_icache_cmu_tagv u_tagv (
        .clk        (clk),
        .reset      (reset),
        .index      (index),
        .tag        (tag),
        .hit0       (hit0),
        .hit1       (hit1),
        .victim     (victim),
        .fill_en    (fill_en),
        .fill_way   (victim),
        .fill_index (index),
        .fill_tag   (tag)
    );

    // Route the bank that holds the hitting way for this index half.
    always_comb begin
        hit_line = ifc.sram_rdata0;
        case (hit_bank)
            2'd1:    hit_line = ifc.sram_rdata1;
            2'd2:    hit_line = ifc.sram_rdata2;
            2'd3:    hit_line = ifc.sram_rdata3;
            default: hit_line = ifc.sram_rdata0;
        endcase
    end

    assign ifc.cmp_allowin = reset ||
        (in_lookup && (!cs_valid || (hit && ifc.fs_allowin)) && !ifc.flush);
    assign ifc.inst_valid  = !reset && cs_valid &&
        ((in_lookup && hit) || ((state == ST_DONE) && !cancel));
    assign ifc.inst        = (state == ST_DONE) ? line_word(line_buf, cs_addr[3:2])
                                                : line_word(hit_line, cs_addr[3:2]);
    assign ifc.inst_pc     = cs_addr;
    assign ifc.mem_rd_req  = !reset && (state == ST_REQ);
    assign ifc.mem_rd_addr = {cs_addr[PC_WD-1:OFFSET_WD], {OFFSET_WD{1'b0}}};
    assign ifc.sram_wen    = fill_en ? ~(4'b0001 << fill_bank) : 4'hF;
    assign ifc.sram_waddr  = index[INDEX_WD-2:0];
    assign ifc.sram_wdata  = line_buf;

    assign accept   = ifc.rs_to_cs_valid && ifc.cmp_allowin;
    assign out_fire = ifc.inst_valid && ifc.fs_allowin;

    // Stage valid: load on accept, drop on delivery or redirect.
    always_ff @(posedge clk) begin
        if (reset)
            cs_valid <= 1'b0;
        else if (accept)
            cs_valid <= 1'b1;
        else if (out_fire || ifc.flush)
            cs_valid <= 1'b0;
    end

    // Stage payload; held through the whole refill so index/tag stay put.
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            cs_addr <= ifc.rs_to_cs_bus[BUS_WD-1:4];
            cs_bank <= ifc.rs_to_cs_bus[3:0];
        end
    end

    // Next-state logic of the lookup/refill sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOOKUP: if (cs_valid && !hit && !ifc.flush) state_nxt = ST_REQ;
            ST_REQ:    if (ifc.mem_rd_ready) state_nxt = ST_RECV;
            ST_RECV:   if (ifc.mem_rd_valid && ifc.mem_rd_last) state_nxt = ST_FILL;
            ST_FILL:   state_nxt = ST_DONE;
            ST_DONE:   if (cancel || !cs_valid || ifc.fs_allowin) state_nxt = ST_LOOKUP;
            default:   state_nxt = ST_LOOKUP;
        endcase
    end

    // State register; reset mid-refill simply drops back to LOOKUP.
    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_LOOKUP;
        else
            state <= state_nxt;
    end

    // A redirect during refill lets the fill finish but silences DONE.
    always_ff @(posedge clk) begin
        if (reset)
            cancel <= 1'b0;
        else if ((state == ST_DONE) && (state_nxt == ST_LOOKUP))
            cancel <= 1'b0;
        else if (ifc.flush && ((state == ST_REQ) || (state == ST_RECV) || (state == ST_FILL)))
            cancel <= 1'b1;
    end

    // Assemble the refill line: the last beat carries the upper half.
    always_ff @(posedge clk) begin
        if ((state == ST_RECV) && ifc.mem_rd_valid) begin
            if (ifc.mem_rd_last)
                line_buf[127:64] <= ifc.mem_rd_data;
            else
                line_buf[63:0] <= ifc.mem_rd_data;
        end
    end

    // A hit may only be served from a bank that upstream actually read.
    always_ff @(posedge clk) begin
        if (!reset && in_lookup && out_fire)
            assert (cs_bank[hit_bank]);
    end
endmodule

// File: tb/tb_ysyx_22041752_icache_cmu.sv
module tb_ysyx_22041752_icache_cmu;
    import ysyx_22041752_icache_cmu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ysyx_22041752_icache_cmu_if ifc();
    ysyx_22041752_icache_cmu dut (.clk(clk), .reset(reset), .ifc(ifc));

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t         sb_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    int           n_rd_req = 0;
    int           n_fill   = 0;
    int           n_iv     = 0;
    logic [3:0]   last_wen;
    logic [5:0]   last_waddr;
    logic [63:0]  exp_line;
    logic [127:0] bank [4][64];
    logic [127:0] rd   [4];

    assign ifc.sram_rdata0 = rd[0];
    assign ifc.sram_rdata1 = rd[1];
    assign ifc.sram_rdata2 = rd[2];
    assign ifc.sram_rdata3 = rd[3];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_A5A5;
    endfunction

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    // SRAM banks: write on active-low wen, read on upstream accept.
    always @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (!ifc.sram_wen[n])
                bank[n][ifc.sram_waddr] <= ifc.sram_wdata;
            if (ifc.rs_to_cs_valid && ifc.cmp_allowin && ifc.rs_to_cs_bus[n])
                rd[n] <= bank[n][ifc.rs_to_cs_bus[13:8]];
        end
    end

    // Observe bank writes and any inst_valid.
    always @(negedge clk) begin
        if (ifc.sram_wen != 4'hF) begin
            n_fill++;
            last_wen   = ifc.sram_wen;
            last_waddr = ifc.sram_waddr;
        end
        if (ifc.inst_valid)
            n_iv++;
    end

    // Scoreboard: pop and compare on every downstream transfer.
    always @(negedge clk) begin
        if (!reset && ifc.inst_valid && ifc.fs_allowin) begin
            check_val("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check_val("inst", ifc.inst, e.inst);
                check_val("inst_pc", ifc.inst_pc, e.pc);
            end
        end
    end

    // Memory: grant a request, then return two beats of the line.
    initial begin
        logic [63:0] la;
        ifc.mem_rd_ready = 1'b0;
        ifc.mem_rd_valid = 1'b0;
        ifc.mem_rd_data  = '0;
        ifc.mem_rd_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && ifc.mem_rd_req) begin
                check_val("rd_addr", ifc.mem_rd_addr, exp_line);
                la = ifc.mem_rd_addr;
                n_rd_req++;
                ifc.mem_rd_ready = 1'b1;
                @(negedge clk);
                ifc.mem_rd_ready = 1'b0;
                ifc.mem_rd_valid = 1'b1;
                ifc.mem_rd_data  = {mem_word(la + 64'd4), mem_word(la)};
                ifc.mem_rd_last  = 1'b0;
                @(negedge clk);
                ifc.mem_rd_data  = {mem_word(la + 64'd12), mem_word(la + 64'd8)};
                ifc.mem_rd_last  = 1'b1;
                @(negedge clk);
                ifc.mem_rd_valid = 1'b0;
                ifc.mem_rd_last  = 1'b0;
            end
        end
    end

    task automatic send(input logic [63:0] addr, input bit miss, input bit way, input int stall);
        int         n_rd0, n_fill0, k;
        logic [3:0] ew;
        exp_t       e;
        ew       = ~(4'b0001 << {way, addr[10]});
        n_rd0    = n_rd_req;
        n_fill0  = n_fill;
        exp_line = {addr[63:4], 4'b0};
        e.pc     = addr;
        e.inst   = mem_word({addr[63:2], 2'b0});
        drive_edge();
        ifc.fs_allowin     = (stall == 0);
        ifc.rs_to_cs_valid = 1'b1;
        ifc.rs_to_cs_bus   = {addr, addr[10] ? 4'b1010 : 4'b0101};
        k = 0;
        @(negedge clk);
        while (!ifc.cmp_allowin && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_val("accept_wait", 64'(k < 50), 64'd1);
        sb_q.push_back(e);
        drive_edge();
        ifc.rs_to_cs_valid = 1'b0;
        @(negedge clk);
        check_val(miss ? "miss_no_early_inst" : "hit_latency", ifc.inst_valid, 64'(!miss));
        for (int i = 0; i < stall; i++) begin
            if (i > 0)
                @(negedge clk);
            check_val("stall_valid", ifc.inst_valid, 64'd1);
            check_val("stall_inst", ifc.inst, e.inst);
            check_val("stall_pc", ifc.inst_pc, addr);
            check_val("stall_allowin", ifc.cmp_allowin, 64'd0);
        end
        if (stall > 0) begin
            drive_edge();
            ifc.fs_allowin = 1'b1;
        end
        k = 0;
        while (sb_q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_val("done_wait", 64'(k < 100), 64'd1);
        drive_edge();
        check_val("rd_req_count", 64'(n_rd_req - n_rd0), 64'(miss));
        check_val("fill_count", 64'(n_fill - n_fill0), 64'(miss));
        if (miss) begin
            check_val("fill_wen", last_wen, ew);
            check_val("fill_waddr", last_waddr, addr[9:4]);
        end
    endtask

    task automatic send_flush(input logic [63:0] addr);
        int n_rd0, n_fill0, n_iv0, k;
        n_rd0    = n_rd_req;
        n_fill0  = n_fill;
        exp_line = {addr[63:4], 4'b0};
        drive_edge();
        ifc.fs_allowin     = 1'b1;
        ifc.rs_to_cs_valid = 1'b1;
        ifc.rs_to_cs_bus   = {addr, addr[10] ? 4'b1010 : 4'b0101};
        @(negedge clk);
        check_val("fl_accept", ifc.cmp_allowin, 64'd1);
        drive_edge();
        ifc.rs_to_cs_valid = 1'b0;
        n_iv0 = n_iv;
        k = 0;
        while (n_rd_req == n_rd0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_val("fl_req_wait", 64'(k < 50), 64'd1);
        drive_edge();
        ifc.flush = 1'b1;
        drive_edge();
        ifc.flush = 1'b0;
        k = 0;
        @(negedge clk);
        while (!(ifc.cmp_allowin && n_fill != n_fill0) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_val("fl_return", 64'(k < 50), 64'd1);
        check_val("fl_fill_count", 64'(n_fill - n_fill0), 64'd1);
        check_val("fl_no_inst", 64'(n_iv - n_iv0), 64'd0);
        check_val("fl_rd_count", 64'(n_rd_req - n_rd0), 64'd1);
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_allowin"}, ifc.cmp_allowin, 64'd1);
        check_val({tag, "_inst_valid"}, ifc.inst_valid, 64'd0);
        check_val({tag, "_mem_rd_req"}, ifc.mem_rd_req, 64'd0);
        check_val({tag, "_sram_wen"}, ifc.sram_wen, 64'hF);
    endtask

    initial begin
        reset              = 1'b1;
        ifc.rs_to_cs_valid = 1'b0;
        ifc.rs_to_cs_bus   = '0;
        ifc.fs_allowin     = 1'b1;
        ifc.flush          = 1'b0;
        exp_line           = '0;
        repeat (2) @(negedge clk);
        check_idle("in_reset");
        drive_edge();
        reset = 1'b0;
        @(negedge clk);
        check_idle("post_reset");

        send(64'h8000_0000, 1'b1, 1'b0, 0);   // cold miss, way0, bank0
        send(64'h8000_0004, 1'b0, 1'b0, 0);   // hit word1
        send(64'h8000_0800, 1'b1, 1'b1, 0);   // set 0, second way -> bank2
        send(64'h8000_0808, 1'b0, 1'b1, 0);
        send(64'h8000_1000, 1'b1, 1'b0, 0);   // set full: FIFO evicts way0
        send(64'h8000_0000, 1'b1, 1'b1, 0);   // evicted line misses, replaces way1
        send(64'h8000_100C, 1'b0, 1'b0, 0);
        send(64'h8000_1008, 1'b0, 1'b0, 3);   // back-pressured hit
        send(64'h8000_0400, 1'b1, 1'b0, 0);   // index 64 -> bank1, waddr 0
        send(64'h8000_040C, 1'b0, 1'b0, 0);
        send_flush(64'h8000_2010);            // flush during refill
        send(64'h8000_2014, 1'b0, 1'b0, 0);   // flushed refill still filled
        send(64'h8000_0004, 1'b0, 1'b1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, checks %0d", n_checks);
        $fatal(1);
    end
endmodule
